// File: rtl/writeback_stage.sv
// Writeback stage: retires one instruction per handshake and drives the register file write port.
// ALU results write one cycle after acceptance; loads wait for memory, extract and extend, then write.
module writeback_stage #(
    parameter int LOAD_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_regwrite,
    input  logic [4:0]  in_waddr,
    input  logic [31:0] in_alu_result,
    input  logic        in_is_load,
    input  logic [1:0]  in_load_size,
    input  logic        in_load_signed,
    input  logic [1:0]  in_addr_low,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wsign,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [0:0]       ST_IDLE      = 1'b0;
    localparam logic [0:0]       ST_WAIT_LOAD = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(LOAD_TIMEOUT - 1);

    // Big-endian lane select followed by sign/zero extension; reserved size behaves as word.
    function automatic logic [31:0] extract_load(
        input logic [31:0] rdata,
        input logic [1:0]  size,
        input logic        sgn,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[31:24];
        h = rdata[31:16];
        case (off)
            2'd0:    b = rdata[31:24];
            2'd1:    b = rdata[23:16];
            2'd2:    b = rdata[15:8];
            2'd3:    b = rdata[7:0];
            default: b = rdata[31:24];
        endcase
        if (off[1]) begin
            h = rdata[15:0];
        end else begin
            h = rdata[31:16];
        end
        case (size)
            2'b00:   extract_load = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            2'b01:   extract_load = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: extract_load = rdata;
        endcase
    endfunction

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_lat_waddr;
    logic             r_lat_regwrite;
    logic [1:0]       r_lat_size;
    logic             r_lat_signed;
    logic [1:0]       r_lat_addr_low;
    logic             r_wsign;
    logic [4:0]       r_waddr;
    logic [31:0]      r_wdata;
    logic             r_timeout_err;

    logic             w_accept;
    logic             w_load_done;
    logic             w_timeout;
    logic [31:0]      w_load_data;

    // Handshake and load-completion decode.
    always_comb begin
        w_accept    = 1'b0;
        w_load_done = 1'b0;
        w_timeout   = 1'b0;
        w_load_data = extract_load(mem_rdata, r_lat_size, r_lat_signed, r_lat_addr_low);
        if (r_state == ST_IDLE) begin
            w_accept = in_valid;
        end else begin
            w_load_done = mem_rvalid;
            w_timeout   = !mem_rvalid && (r_cnt == CNT_LAST);
        end
    end

    // FSM, watchdog counter and latched load fields.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_lat_waddr    <= 5'd0;
            r_lat_regwrite <= 1'b0;
            r_lat_size     <= 2'd0;
            r_lat_signed   <= 1'b0;
            r_lat_addr_low <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && in_is_load) begin
                        r_lat_waddr    <= in_waddr;
                        r_lat_regwrite <= in_regwrite;
                        r_lat_size     <= in_load_size;
                        r_lat_signed   <= in_load_signed;
                        r_lat_addr_low <= in_addr_low;
                        r_cnt          <= '0;
                        r_state        <= ST_WAIT_LOAD;
                    end
                end
                ST_WAIT_LOAD: begin
                    if (w_load_done || w_timeout) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Register file write port and sticky timeout flag; wsign pulses once per completion.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wsign       <= 1'b0;
            r_waddr       <= 5'd0;
            r_wdata       <= 32'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wsign <= 1'b0;
            if (w_accept && !in_is_load) begin
                r_wsign <= in_regwrite && (in_waddr != 5'd0);
                r_waddr <= in_waddr;
                r_wdata <= in_alu_result;
            end else if (w_load_done) begin
                r_wsign <= r_lat_regwrite && (r_lat_waddr != 5'd0);
                r_waddr <= r_lat_waddr;
                r_wdata <= w_load_data;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state == ST_WAIT_LOAD);
    assign wsign       = r_wsign;
    assign waddr       = r_waddr;
    assign wdata       = r_wdata;
    assign timeout_err = r_timeout_err;

endmodule
